instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Supplier side of the decoder instruction interface: drives `instruction` and `stall_from_instructionfetch` into the CPU top.
- Obeys the CPU's `stall_to_instructionfetch`, `decoder_pc_update` and `RF_pc_out`.
- Fetches 16-bit Thumb halfwords from the shared single-port 16-bit memory through a request/grant port on the memory arbiter.
- Buffers prefetched halfwords in a small FIFO so the decoder sees one instruction per cycle when memory keeps up.

Parameters:
DEPTH  4  prefetch FIFO entries (power of two, 2..8)
RESET_PC  32'h0000_0000  byte address of first fetch after reset
NOP_INSTR  16'h0000  value driven on instruction while FIFO empty

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset (0 = in reset)
instruction  out  16  FIFO head halfword to decoder
instruction_pc  out  32  byte address of current instruction
stall_from_instructionfetch  out  1  1 = no valid instruction (FIFO empty)
stall_to_instructionfetch  in  1  1 = decoder holds; do not consume head
decoder_pc_update  in  1  1 = branch/pop-to-pc, flush and redirect
RF_pc_out  in  32  redirect target, valid when decoder_pc_update=1
imem_req  out  1  fetch request to arbiter
imem_grant  in  1  arbiter accepts request this cycle
imem_addr  out  12  halfword address = fetch_pc[12:1]
imem_rdata  in  16  read data, valid the cycle after a grant

Behaviour:
- Reset values (async, while reset=0): fetch_pc=RESET_PC, FIFO empty, inflight=0, state=S_IDLE, imem_req=0, imem_addr=0, instruction=NOP_INSTR, instruction_pc=RESET_PC, stall_from_instructionfetch=1.
- Reset released mid-operation: all queued and in-flight data is lost; restart from RESET_PC.
- FSM states:
  - S_IDLE: one cycle after reset release, no request; then S_RUN.
  - S_RUN: normal prefetch.
  - S_FLUSH: entered on decoder_pc_update; one cycle, no request; then S_RUN.
- Issue rule (S_RUN, no pc_update this cycle): imem_req=1 iff count + inflight < DEPTH, using registered values. No pop credit.
- imem_addr=fetch_pc[12:1] while requesting; holds its last value otherwise.
- On req & grant: fetch_pc += 2; inflight=1; response PC tag = the issued fetch_pc.
- On req & !grant: retry same address next cycle, fetch_pc unchanged.
- Response: the cycle after a grant, imem_rdata and its PC tag are pushed to the FIFO tail, unless discarded.
- Pipelined issue is allowed; at most one response returns per cycle.
- Latency: granted request in cycle N -> data captured end of N+1 -> visible on instruction in N+2.
- Output: when FIFO non-empty, instruction=head, instruction_pc=head tag, stall_from_instructionfetch=0. When empty: instruction=NOP_INSTR, stall=1, instruction_pc holds last value.
- Pop: head consumed at clock edge iff FIFO non-empty & stall_to_instructionfetch=0 & decoder_pc_update=0.
- Push and pop in the same cycle: both occur, count unchanged.
- Flush (decoder_pc_update=1, overrides stall and pop):
  - FIFO cleared; fetch_pc <= {RF_pc_out[31:1],1'b0} (bit 0 Thumb bit ignored).
  - Epoch bit toggles; a response returning in the next cycle carries the old epoch and is discarded.
  - imem_req=0 this cycle and in S_FLUSH.
  - First redirected request is issued 2 cycles after the pc_update cycle.
- Back-to-back pc_update: the last one wins; each one restarts S_FLUSH.
- Wrap: only fetch_pc[12:1] addresses memory. 0x1FFE+2 -> imem_addr 0; fetch_pc itself keeps full 32-bit increment.
- FIFO never overflows (guaranteed by issue rule). An assertion fires on push while full.

Test Plan:
- Reset release, grant always 1, mem[0..3]=B580,AF02,2300,1C18 -> first instruction B580 with instruction_pc 0 two cycles after first req; then AF02, 2300, 1C18 on consecutive cycles; stall=0 throughout.
- Decoder stall=1 for 3 cycles while FIFO holds AF02 -> instruction stays AF02; count reaches DEPTH; imem_req drops to 0; resumes in order after stall=0.
- pc_update=1 with RF_pc_out=0x0000_0041 while a response is in flight -> in-flight data dropped, stall=1, next imem_addr=0x020. First new instruction = mem[0x020], instruction_pc 0x40.
- imem_grant held 0 for 4 cycles -> imem_req stays 1 with constant imem_addr; FIFO drains; stall=1 and instruction=0000 once empty; fetch resumes on grant.
- fetch_pc at 0x1FFC, stream runs -> imem_addr sequence 0xFFE, 0xFFF, 0x000; instruction_pc 0x1FFC, 0x1FFE, 0x2000.
- reset=0 asserted mid-stream with FIFO at 3 entries -> outputs take reset values immediately (asynchronous). After release, fetch restarts at imem_addr 0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Request/grant port between the instruction fetch unit and the shared
// 16-bit memory arbiter.
interface instruction_fetch_if;
   logic        imem_req;
   logic        imem_grant;
   logic [11:0] imem_addr;
   logic [15:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_grant, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_grant, output imem_rdata);
endinterface

// File: rtl/instruction_fetch.sv
// Thumb halfword prefetcher: fetches through the memory arbiter into a small
// FIFO and presents one instruction per cycle to the decoder.
//
// state   | meaning
// S_IDLE  | first cycle after reset release, no request
// S_RUN   | normal prefetch, request while FIFO + in-flight has room
// S_FLUSH | one dead cycle after a decoder redirect, no request
module instruction_fetch #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [15:0] NOP_INSTR = 16'h0000
) (
   input  logic                 clock,
   input  logic                 reset,
   output logic [15:0]          instruction,
   output logic [31:0]          instruction_pc,
   output logic                 stall_from_instructionfetch,
   input  logic                 stall_to_instructionfetch,
   input  logic                 decoder_pc_update,
   input  logic [31:0]          RF_pc_out,
   instruction_fetch_if.master  imem
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW:0]   DEPTH_O = (CW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

   state_t        state, state_nxt;
   logic [31:0]   fetch_pc;
   logic [11:0]   addr_q;
   logic          epoch;
   logic          inflight;
   logic          inflight_epoch;
   logic [31:0]   inflight_pc;
   logic [31:0]   last_pc;
   logic [15:0]   fifo_data [DEPTH];
   logic [31:0]   fifo_pc   [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic [CW:0]   occupancy;
   logic          req, grant_hit, push, pop, empty, full;

   assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign empty     = (count == '0);
   assign full      = (count == DEPTH_C);
   assign grant_hit = req & imem.imem_grant;
   // A response that returns while a redirect is in progress, or carries a
   // stale epoch, never reaches the FIFO.
   assign push      = inflight & (inflight_epoch == epoch) & ~decoder_pc_update;
   assign pop       = ~empty & ~stall_to_instructionfetch & ~decoder_pc_update;

   always_comb begin
      state_nxt = state;
      req       = 1'b0;
      case (state)
         S_IDLE:  state_nxt = S_RUN;
         S_RUN:   req = (occupancy < DEPTH_O);
         S_FLUSH: state_nxt = S_RUN;
         default: state_nxt = S_IDLE;
      endcase
      if (decoder_pc_update) begin
         state_nxt = S_FLUSH;
         req       = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         fetch_pc       <= RESET_PC;
         addr_q         <= 12'h000;
         epoch          <= 1'b0;
         inflight       <= 1'b0;
         inflight_epoch <= 1'b0;
         inflight_pc    <= RESET_PC;
         last_pc        <= RESET_PC;
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         count          <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= grant_hit;
         if (req) addr_q <= fetch_pc[12:1];
         if (grant_hit) begin
            inflight_pc    <= fetch_pc;
            inflight_epoch <= epoch;
         end
         if (decoder_pc_update) begin
            fetch_pc <= {RF_pc_out[31:1], 1'b0};
            epoch    <= ~epoch;
         end else if (grant_hit) begin
            fetch_pc <= fetch_pc + 32'd2;
         end
         if (!empty) last_pc <= fifo_pc[rd_ptr];
         if (decoder_pc_update) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_data[wr_ptr] <= imem.imem_rdata;
         fifo_pc[wr_ptr]   <= inflight_pc;
      end
   end

   assign imem.imem_req   = req;
   assign imem.imem_addr  = req ? fetch_pc[12:1] : addr_q;

   assign instruction                 = empty ? NOP_INSTR : fifo_data[rd_ptr];
   assign instruction_pc              = empty ? last_pc : fifo_pc[rd_ptr];
   assign stall_from_instructionfetch = empty;

   a_no_overflow: assert property (@(posedge clock) disable iff (!reset) !(push && full));
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a one-cycle-latency memory model.
module tb_instruction_fetch;
   logic        clock;
   logic        reset;
   logic        stall_to;
   logic        pc_update;
   logic [31:0] rf_pc;
   logic [15:0] instruction;
   logic [31:0] instruction_pc;
   logic        stall_from;
   logic        grant_en;
   logic [15:0] rdata_q;
   logic [15:0] mem [4096];
   int          passed;
   int          total;

   instruction_fetch_if bus ();

   instruction_fetch #(.DEPTH(4), .RESET_PC(32'h0), .NOP_INSTR(16'h0000)) dut (
      .clock                       (clock),
      .reset                       (reset),
      .instruction                 (instruction),
      .instruction_pc              (instruction_pc),
      .stall_from_instructionfetch (stall_from),
      .stall_to_instructionfetch   (stall_to),
      .decoder_pc_update           (pc_update),
      .RF_pc_out                   (rf_pc),
      .imem                        (bus.master)
   );

   assign bus.imem_grant = grant_en;
   assign bus.imem_rdata = rdata_q;

   always @(posedge clock)
      if (bus.imem_req && bus.imem_grant) rdata_q <= mem[bus.imem_addr];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      stall_to  = 1'b0;
      pc_update = 1'b0;
      rf_pc     = 32'h0;
      grant_en  = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall_to = 1'b0; pc_update = 1'b0; rf_pc = 32'h0; grant_en = 1'b1;
      #2 reset = 1'b0;
      step();
      total++; if (instruction !== 16'h0000) $display("FAIL reset_instr: got %h want 0000", instruction); else passed++;
      total++; if (instruction_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", instruction_pc); else passed++;
      total++; if (stall_from !== 1'b1) $display("FAIL reset_stall: got %b want 1", stall_from); else passed++;
      total++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.imem_req); else passed++;
      total++; if (bus.imem_addr !== 12'h000) $display("FAIL reset_addr: got %h want 000", bus.imem_addr); else passed++;
   endtask

   task automatic test_stream();
      logic [15:0] exp_i [3];
      logic [31:0] exp_p [3];
      exp_i[0] = 16'hAF02; exp_i[1] = 16'h2300; exp_i[2] = 16'h1C18;
      exp_p[0] = 32'h2;    exp_p[1] = 32'h4;    exp_p[2] = 32'h6;
      do_reset();
      step();
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h000) $display("FAIL stream_req0: got %b/%h want 1/000", bus.imem_req, bus.imem_addr); else passed++;
      total++; if (stall_from !== 1'b1) $display("FAIL stream_stall0: got %b want 1", stall_from); else passed++;
      step();
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h001) $display("FAIL stream_req1: got %b/%h want 1/001", bus.imem_req, bus.imem_addr); else passed++;
      step();
      total++; if (instruction !== 16'hB580 || instruction_pc !== 32'h0 || stall_from !== 1'b0)
         $display("FAIL stream_first: got %h/%h/%b want B580/00000000/0", instruction, instruction_pc, stall_from); else passed++;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (instruction !== exp_i[i] || instruction_pc !== exp_p[i] || stall_from !== 1'b0)
            $display("FAIL stream_seq%0d: got %h/%h/%b want %h/%h/0", i, instruction, instruction_pc, stall_from, exp_i[i], exp_p[i]); else passed++;
      end
   endtask

   task automatic test_decoder_stall();
      do_reset();
      repeat (4) step();
      stall_to = 1'b1;
      step();
      total++; if (instruction !== 16'hAF02) $display("FAIL dstall_hold1: got %h want AF02", instruction); else passed++;
      step();
      total++; if (instruction !== 16'hAF02 || bus.imem_req !== 1'b0) $display("FAIL dstall_hold2: got %h/%b want AF02/0", instruction, bus.imem_req); else passed++;
      step();
      total++; if (instruction !== 16'hAF02 || bus.imem_req !== 1'b0) $display("FAIL dstall_full: got %h/%b want AF02/0", instruction, bus.imem_req); else passed++;
      stall_to = 1'b0;
      step();
      total++; if (instruction !== 16'h2300 || instruction_pc !== 32'h4) $display("FAIL dstall_resume0: got %h/%h want 2300/4", instruction, instruction_pc); else passed++;
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h005) $display("FAIL dstall_rereq: got %b/%h want 1/005", bus.imem_req, bus.imem_addr); else passed++;
      step();
      total++; if (instruction !== 16'h1C18 || instruction_pc !== 32'h6) $display("FAIL dstall_resume1: got %h/%h want 1C18/6", instruction, instruction_pc); else passed++;
      step();
      total++; if (instruction !== 16'hA004 || instruction_pc !== 32'h8) $display("FAIL dstall_resume2: got %h/%h want A004/8", instruction, instruction_pc); else passed++;
   endtask

   task automatic test_flush();
      do_reset();
      repeat (4) step();
      pc_update = 1'b1; rf_pc = 32'h0000_0041;
      #1;
      total++; if (bus.imem_req !== 1'b0) $display("FAIL flush_req_upd: got %b want 0", bus.imem_req); else passed++;
      step();
      total++; if (stall_from !== 1'b1 || instruction !== 16'h0000) $display("FAIL flush_empty: got %b/%h want 1/0000", stall_from, instruction); else passed++;
      total++; if (instruction_pc !== 32'h2 || bus.imem_req !== 1'b0) $display("FAIL flush_hold: got %h/%b want 2/0", instruction_pc, bus.imem_req); else passed++;
      pc_update = 1'b0;
      step();
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h020) $display("FAIL flush_redirect: got %b/%h want 1/020", bus.imem_req, bus.imem_addr); else passed++;
      total++; if (stall_from !== 1'b1) $display("FAIL flush_drop1: got %b want 1", stall_from); else passed++;
      step();
      total++; if (stall_from !== 1'b1) $display("FAIL flush_drop2: got %b want 1", stall_from); else passed++;
      step();
      total++; if (instruction !== 16'hA020 || instruction_pc !== 32'h40 || stall_from !== 1'b0)
         $display("FAIL flush_target: got %h/%h/%b want A020/40/0", instruction, instruction_pc, stall_from); else passed++;
   endtask

   task automatic test_grant_stall();
      do_reset();
      repeat (4) step();
      grant_en = 1'b0;
      step();
      total++; if (instruction !== 16'h2300 || bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h003)
         $display("FAIL gstall_c1: got %h/%b/%h want 2300/1/003", instruction, bus.imem_req, bus.imem_addr); else passed++;
      step();
      total++; if (stall_from !== 1'b1 || instruction !== 16'h0000 || instruction_pc !== 32'h4)
         $display("FAIL gstall_empty: got %b/%h/%h want 1/0000/4", stall_from, instruction, instruction_pc); else passed++;
      for (int i = 0; i < 3; i++) begin
         total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h003)
            $display("FAIL gstall_retry%0d: got %b/%h want 1/003", i, bus.imem_req, bus.imem_addr); else passed++;
         if (i < 2) step();
      end
      grant_en = 1'b1;
      step();
      total++; if (stall_from !== 1'b1) $display("FAIL gstall_lat: got %b want 1", stall_from); else passed++;
      step();
      total++; if (instruction !== 16'h1C18 || instruction_pc !== 32'h6 || stall_from !== 1'b0)
         $display("FAIL gstall_resume: got %h/%h/%b want 1C18/6/0", instruction, instruction_pc, stall_from); else passed++;
   endtask

   task automatic test_wrap();
      logic [11:0] exp_a [3];
      exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000;
      do_reset();
      step();
      pc_update = 1'b1; rf_pc = 32'h0000_1FFC;
      step();
      pc_update = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_a[i])
            $display("FAIL wrap_addr%0d: got %b/%h want 1/%h", i, bus.imem_req, bus.imem_addr, exp_a[i]); else passed++;
      end
      total++; if (instruction !== 16'hAFFE || instruction_pc !== 32'h1FFC) $display("FAIL wrap_i0: got %h/%h want AFFE/1FFC", instruction, instruction_pc); else passed++;
      step();
      total++; if (instruction !== 16'hAFFF || instruction_pc !== 32'h1FFE) $display("FAIL wrap_i1: got %h/%h want AFFF/1FFE", instruction, instruction_pc); else passed++;
      step();
      total++; if (instruction !== 16'hB580 || instruction_pc !== 32'h2000) $display("FAIL wrap_i2: got %h/%h want B580/2000", instruction, instruction_pc); else passed++;
   endtask

   task automatic test_reset_midstream();
      do_reset();
      stall_to = 1'b1;
      repeat (5) step();
      total++; if (stall_from !== 1'b0 || instruction !== 16'hB580) $display("FAIL mid_prefill: got %b/%h want 0/B580", stall_from, instruction); else passed++;
      reset = 1'b0;
      #1;
      total++; if (instruction !== 16'h0000 || stall_from !== 1'b1) $display("FAIL mid_rst_out: got %h/%b want 0000/1", instruction, stall_from); else passed++;
      total++; if (instruction_pc !== 32'h0 || bus.imem_req !== 1'b0 || bus.imem_addr !== 12'h000)
         $display("FAIL mid_rst_bus: got %h/%b/%h want 0/0/000", instruction_pc, bus.imem_req, bus.imem_addr); else passed++;
      repeat (2) step();
      reset = 1'b1; stall_to = 1'b0;
      step();
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h000) $display("FAIL mid_restart: got %b/%h want 1/000", bus.imem_req, bus.imem_addr); else passed++;
      repeat (2) step();
      total++; if (instruction !== 16'hB580 || instruction_pc !== 32'h0) $display("FAIL mid_first: got %h/%h want B580/0", instruction, instruction_pc); else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rdata_q = 16'h0;
      for (int i = 0; i < 4096; i++) mem[i] = 16'hA000 | 16'(i);
      mem[0] = 16'hB580; mem[1] = 16'hAF02; mem[2] = 16'h2300; mem[3] = 16'h1C18;
      test_reset();
      test_stream();
      test_decoder_stall();
      test_flush();
      test_grant_stall();
      test_wrap();
      test_reset_midstream();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
